// File: rtl/fib_pkg.sv
// fib_pkg: shared Fibonacci state encoding and default widths
package fib_pkg;
  localparam int FIB_WIDTH = 32;
  localparam int FIB_NW    = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fib_state_t;
endpackage

// File: rtl/fib_index.sv
// fib_index: finds the largest n with F(n) <= T by stepping the sequence once per clock
module fib_index
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int NW    = FIB_NW
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_stb,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_busy,
  output logic             o_valid,
  output logic [NW-1:0]    o_n,
  output logic [WIDTH-1:0] o_fib,
  output logic             o_exact
);
  fib_state_t       r_state;
  logic [WIDTH-1:0] r_target, r_cur, r_prev, r_fib;
  logic [NW-1:0]    r_idx, r_n;
  logic             r_valid, r_exact;
  logic [WIDTH:0]   w_nxt;
  logic             w_over;
  // a carry into bit WIDTH always exceeds the zero-extended target, so wrap never yields a result
  assign w_nxt   = {1'b0, r_cur} + {1'b0, r_prev};
  assign w_over  = w_nxt > {1'b0, r_target};
  assign o_busy  = r_state != IDLE;
  assign o_valid = r_valid;
  assign o_n     = r_n;
  assign o_fib   = r_fib;
  assign o_exact = r_exact;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_cur    <= '0;
      r_prev   <= WIDTH'(1);
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_n      <= '0;
      r_fib    <= '0;
      r_exact  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_stb) begin
          r_state  <= RUN;
          r_target <= i_value;
          r_cur    <= '0;
          r_prev   <= WIDTH'(1);
          r_idx    <= '0;
        end
        RUN: if (!w_over) begin
          r_prev <= r_cur;
          r_cur  <= w_nxt[WIDTH-1:0];
          r_idx  <= r_idx + NW'(1);
        end else begin
          r_state <= DONE;
          r_valid <= 1'b1;
          r_n     <= r_idx;
          r_fib   <= r_cur;
          r_exact <= r_cur == r_target;
        end
        DONE: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_index.sv
// tb_fib_index: directed and randomized checks of fib_index against a plain-arithmetic model
module tb_fib_index;
  localparam int W = 32;
  localparam int N = 8;
  logic         clk = 1'b0, rst_n = 1'b0, stb = 1'b0;
  logic [W-1:0] value = '0;
  logic         o_busy, o_valid, o_exact;
  logic [N-1:0] o_n;
  logic [W-1:0] o_fib;
  int total = 0, bad = 0;
  int ob_n, ob_busy, ob_vcyc, ob_vcnt;
  logic [W-1:0] ob_fib;
  logic ob_exact;

  fib_index #(.WIDTH(W), .NW(N)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_value(value),
    .o_busy(o_busy), .o_valid(o_valid), .o_n(o_n), .o_fib(o_fib), .o_exact(o_exact)
  );

  always #5 clk = ~clk;

  // walk pairs (F(n), F(n+1)) until the next one would pass t
  function automatic void ref_fib(input longint t, output int n, output longint f);
    longint a = 0, b = 1, s;
    n = 0;
    while (b <= t) begin
      s = a + b; a = b; b = s; n++;
    end
    f = a;
  endfunction

  // issue one request; poke>0 raises i_stb with value 5 during that busy cycle
  task automatic do_req(input logic [W-1:0] t, input int poke);
    ob_busy = 0; ob_vcyc = 0; ob_vcnt = 0; ob_n = -1; ob_fib = 'x; ob_exact = 1'bx;
    stb = 1'b1; value = t;
    @(posedge clk); #1;
    stb = 1'b0;
    for (int c = 1; c <= 200 && o_busy; c++) begin
      if (c == poke) begin stb = 1'b1; value = 5; end else stb = 1'b0;
      ob_busy++;
      if (o_valid) begin
        ob_vcyc = c; ob_vcnt++; ob_n = int'(o_n); ob_fib = o_fib; ob_exact = o_exact;
      end
      @(posedge clk); #1;
    end
    stb = 1'b0;
    total++;
    if (o_busy) begin bad++; $display("FAIL timeout t=%0d busy=%b want 0", t, o_busy); end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({o_busy, o_valid, o_n, o_fib, o_exact} !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%b valid=%b n=%0d fib=%0d exact=%b want all 0",
                      o_busy, o_valid, o_n, o_fib, o_exact);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] tv [5] = '{32'd0, 32'd1, 32'd144, 32'd100, 32'hFFFF_FFFF};
    int           en [5] = '{0, 2, 12, 11, 47};
    logic [W-1:0] ef [5] = '{32'd0, 32'd1, 32'd144, 32'd89, 32'd2971215073};
    logic         ex [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_req(tv[i], 0);
      total += 4;
      if (ob_n !== en[i] || ob_fib !== ef[i] || ob_exact !== ex[i]) begin
        bad++; $display("FAIL dir_result t=%0d got n=%0d fib=%0d exact=%b want n=%0d fib=%0d exact=%b",
                        tv[i], ob_n, ob_fib, ob_exact, en[i], ef[i], ex[i]);
      end
      if (ob_busy !== en[i] + 2) begin
        bad++; $display("FAIL dir_busy t=%0d got %0d want %0d", tv[i], ob_busy, en[i] + 2);
      end
      if (ob_vcyc !== en[i] + 2) begin
        bad++; $display("FAIL dir_latency t=%0d got cycle %0d want %0d", tv[i], ob_vcyc, en[i] + 2);
      end
      if (ob_vcnt !== 1) begin
        bad++; $display("FAIL dir_vcount t=%0d got %0d want 1", tv[i], ob_vcnt);
      end
    end
  endtask

  task automatic test_hold;
    logic [N-1:0] n0 = o_n;
    logic [W-1:0] f0 = o_fib;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (o_n !== n0 || o_fib !== f0 || o_exact !== 1'b0 || o_n !== N'(47) || o_valid !== 1'b0) begin
      bad++; $display("FAIL hold got n=%0d fib=%0d exact=%b valid=%b want n=47 fib=2971215073 exact=0 valid=0",
                      o_n, o_fib, o_exact, o_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] t;
      int n;
      longint f;
      case (i % 3)
        0: t = $urandom_range(0, 400);
        1: t = $urandom;
        default: begin
          ref_fib(longint'($urandom_range(0, 2000000)), n, f);
          t = W'(f + longint'($urandom_range(0, 2)) - 1);
        end
      endcase
      ref_fib(longint'(t), n, f);
      do_req(t, 0);
      total += 2;
      if (ob_n !== n || ob_fib !== W'(f) || ob_exact !== (f == longint'(t))) begin
        bad++; $display("FAIL rnd_result t=%0d got n=%0d fib=%0d exact=%b want n=%0d fib=%0d exact=%b",
                        t, ob_n, ob_fib, ob_exact, n, f, f == longint'(t));
      end
      if (ob_vcyc !== n + 2 || ob_busy !== n + 2 || ob_vcnt !== 1) begin
        bad++; $display("FAIL rnd_timing t=%0d got vcyc=%0d busy=%0d vcnt=%0d want %0d/%0d/1",
                        t, ob_vcyc, ob_busy, ob_vcnt, n + 2, n + 2);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int p = 1; p <= 13; p += 4) begin
      do_req(32'd100, p);
      total++;
      if (ob_n !== 11 || ob_fib !== 32'd89 || ob_vcnt !== 1 || ob_busy !== 13) begin
        bad++; $display("FAIL busy_stb poke=%0d got n=%0d fib=%0d vcnt=%0d busy=%0d want 11/89/1/13",
                        p, ob_n, ob_fib, ob_vcnt, ob_busy);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL busy_stb_idle got busy=%b want 0", o_busy); end
  endtask

  task automatic test_reset_abort;
    int vseen = 0;
    stb = 1'b1; value = 32'd100;
    @(posedge clk); #1;
    stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (o_busy !== 1'b1) begin bad++; $display("FAIL abort_pre got busy=%b want 1", o_busy); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_busy, o_valid, o_n, o_fib, o_exact} !== '0) begin
      bad++; $display("FAIL abort_zero got busy=%b valid=%b n=%0d fib=%0d exact=%b want all 0",
                      o_busy, o_valid, o_n, o_fib, o_exact);
    end
    repeat (20) begin
      @(negedge clk);
      if (o_valid) vseen++;
      if (vseen == 0 && !rst_n && $time > 0) rst_n = 1'b1;
    end
    total++;
    if (vseen !== 0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL abort_novalid got valids=%0d busy=%b want 0/0", vseen, o_busy);
    end
    do_req(32'd5, 0);
    total++;
    if (ob_n !== 5 || ob_fib !== 32'd5 || ob_exact !== 1'b1 || ob_vcnt !== 1) begin
      bad++; $display("FAIL abort_after got n=%0d fib=%0d exact=%b vcnt=%0d want 5/5/1/1",
                      ob_n, ob_fib, ob_exact, ob_vcnt);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_random;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
